// File: rtl/iod_delay_line_ctrl.sv
// iod_delay_line_ctrl
// Sequencer for one IOD lane dynamic delay line (DDR4 PHY address/command pin).
// Converts absolute tap-target requests into paced single-tap MOVE pulses with a
// held DIRECTION, or into a LOAD reload, while tracking the current tap.
//
// Optional feature: define IOD_DELAY_CTRL_STEP_COUNT_EN to enable the saturating
// MOVE pulse counter on step_cnt_o; otherwise step_cnt_o is tied to zero.
//
// Ports:
//   fab_clk_i                  fabric clock, rising edge
//   arst_n_i                   asynchronous active-low reset
//   req_valid_i / req_ready_o  request handshake (ready only in IDLE)
//   req_load_i                 1 = reload to INIT_TAP, 0 = move to req_tap_i
//   req_tap_i                  target tap, clamped to MAX_TAP
//   delay_line_out_of_range_i  out-of-range flag from the IOD
//   delay_line_move_o          one-cycle single-tap step pulse
//   delay_line_direction_o     1 = increment delay, 0 = decrement
//   delay_line_load_o          one-cycle reload pulse
//   cur_tap_o                  tracked tap value
//   done_o                     one-cycle completion pulse
//   err_oor_o                  sticky out-of-range error, cleared by a LOAD
//   step_cnt_o                 total MOVE pulses issued (optional)
module iod_delay_line_ctrl #(
  parameter int unsigned TAP_W      = 8,
  parameter int unsigned MAX_TAP    = 255,
  parameter int unsigned INIT_TAP   = 1,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic             fab_clk_i,
  input  logic             arst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_load_i,
  input  logic [TAP_W-1:0] req_tap_i,
  input  logic             delay_line_out_of_range_i,
  output logic             delay_line_move_o,
  output logic             delay_line_direction_o,
  output logic             delay_line_load_o,
  output logic [TAP_W-1:0] cur_tap_o,
  output logic             done_o,
  output logic             err_oor_o,
  output logic [15:0]      step_cnt_o
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned STEP_W = 16;
  localparam logic [TAP_W-1:0] MAX_TAP_T  = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] INIT_TAP_T = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0] ONE_TAP    = TAP_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_MOVE   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TAP_W-1:0] target_q, target_d;
  logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             from_load_q, from_load_d;
  logic             ready_q, ready_d;
  logic             move_q, move_d;
  logic             load_q, load_d;
  logic             done_q, done_d;
  logic [TAP_W-1:0] req_tgt;

  // Requests above the highest legal tap are clamped.
  assign req_tgt = (req_tap_i > MAX_TAP_T) ? MAX_TAP_T : req_tap_i;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    cur_tap_d   = cur_tap_q;
    dir_d       = dir_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    from_load_d = from_load_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i && ready_q) begin
          if (req_load_i) begin
            err_d   = 1'b0;
            state_d = S_LOAD;
          end else begin
            target_d = req_tgt;
            if (req_tgt == cur_tap_q) begin
              state_d = S_DONE;
            end else begin
              dir_d   = (req_tgt > cur_tap_q);
              state_d = S_MOVE;
            end
          end
        end
      end
      S_LOAD: begin
        // Target follows the reload so the settle exit sees a match.
        cur_tap_d   = INIT_TAP_T;
        target_d    = INIT_TAP_T;
        from_load_d = 1'b1;
        cnt_d       = SETTLE_LAST;
        state_d     = S_SETTLE;
      end
      S_MOVE: begin
        cur_tap_d   = dir_q ? (cur_tap_q + ONE_TAP) : (cur_tap_q - ONE_TAP);
        from_load_d = 1'b0;
        cnt_d       = SETTLE_LAST;
        state_d     = S_SETTLE;
      end
      S_SETTLE: begin
        if (delay_line_out_of_range_i && !from_load_q) begin
          // The IOD refused the last step: roll the tracked tap back.
          cur_tap_d = dir_q ? (cur_tap_q - ONE_TAP) : (cur_tap_q + ONE_TAP);
          err_d     = 1'b1;
          state_d   = S_DONE;
        end else if (cnt_q == '0) begin
          state_d = (cur_tap_q == target_q) ? S_DONE : S_MOVE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    move_d  = (state_d == S_MOVE);
    load_d  = (state_d == S_LOAD);
    done_d  = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge fab_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= S_IDLE;
      target_q    <= INIT_TAP_T;
      cur_tap_q   <= INIT_TAP_T;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      from_load_q <= 1'b0;
      ready_q     <= 1'b1;
      move_q      <= 1'b0;
      load_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      cur_tap_q   <= cur_tap_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      from_load_q <= from_load_d;
      ready_q     <= ready_d;
      move_q      <= move_d;
      load_q      <= load_d;
      done_q      <= done_d;
    end
  end

`ifdef IOD_DELAY_CTRL_STEP_COUNT_EN
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;

  // Counts each MOVE pulse as it is launched; saturates at all-ones.
  always_comb begin
    step_cnt_d = step_cnt_q;
    if (move_d && (step_cnt_q != {STEP_W{1'b1}})) begin
      step_cnt_d = step_cnt_q + STEP_W'(1);
    end
  end

  always_ff @(posedge fab_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      step_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_d;
    end
  end

  assign step_cnt_o = step_cnt_q;
`else
  assign step_cnt_o = '0;
`endif

  assign req_ready_o            = ready_q;
  assign delay_line_move_o      = move_q;
  assign delay_line_direction_o = dir_q;
  assign delay_line_load_o      = load_q;
  assign cur_tap_o              = cur_tap_q;
  assign done_o                 = done_q;
  assign err_oor_o              = err_q;

endmodule

// File: tb/tb_iod_delay_line_ctrl.sv
module tb_iod_delay_line_ctrl;

  localparam int unsigned TAP_W    = 8;
  localparam int unsigned MAX_TAP  = 20;
  localparam int unsigned INIT_TAP = 1;
  localparam int unsigned S        = 4;
  localparam int          BUDGET   = 400;

  logic             fab_clk;
  logic             arst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_load;
  logic [TAP_W-1:0] req_tap;
  logic             oor;
  logic             mv;
  logic             dir;
  logic             ld_o;
  logic [TAP_W-1:0] cur_tap;
  logic             done;
  logic             err_oor;
  logic [15:0]      step_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model of the block's architectural state.
  int m_cur   = INIT_TAP;
  bit m_err   = 1'b0;
  bit m_dir   = 1'b0;
  int m_steps = 0;

  iod_delay_line_ctrl #(
    .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .INIT_TAP(INIT_TAP), .SETTLE_CYC(S)
  ) dut (
    .fab_clk_i                 (fab_clk),
    .arst_n_i                  (arst_n),
    .req_valid_i               (req_valid),
    .req_ready_o               (req_ready),
    .req_load_i                (req_load),
    .req_tap_i                 (req_tap),
    .delay_line_out_of_range_i (oor),
    .delay_line_move_o         (mv),
    .delay_line_direction_o    (dir),
    .delay_line_load_o         (ld_o),
    .cur_tap_o                 (cur_tap),
    .done_o                    (done),
    .err_oor_o                 (err_oor),
    .step_cnt_o                (step_cnt)
  );

  initial fab_clk = 1'b0;
  always #5 fab_clk = ~fab_clk;

  function automatic logic [15:0] exp_steps();
`ifdef IOD_DELAY_CTRL_STEP_COUNT_EN
    return (m_steps > 65535) ? 16'hFFFF : 16'(m_steps);
`else
    return 16'h0;
`endif
  endfunction

  // Issue one request and follow it to DONE, comparing every cycle with the model.
  // oor_p/oor_j: raise OUT_OF_RANGE in settle cycle oor_j after pulse oor_p (0 = never).
  task automatic run_req(input bit ld, input int tap, input int oor_p, input int oor_j,
                         input bit oor_on_load, input string nm);
    int  tgt, n, exp_pulses, exp_done, oor_cyc, nxt_cur, pulses;
    bit  exp_dir, nxt_err, done_seen;
    oor_cyc = -1;
    exp_dir = m_dir;
    if (ld) begin
      exp_pulses = 0;
      exp_done   = 2 + S;
      nxt_cur    = INIT_TAP;
      nxt_err    = 1'b0;
    end else begin
      tgt = (tap > MAX_TAP) ? MAX_TAP : tap;
      n   = (tgt > m_cur) ? tgt - m_cur : m_cur - tgt;
      nxt_err = m_err;
      if (n == 0) begin
        exp_pulses = 0;
        exp_done   = 1;
        nxt_cur    = m_cur;
      end else begin
        exp_dir = (tgt > m_cur);
        if (oor_p > 0 && oor_p <= n) begin
          exp_pulses = oor_p;
          oor_cyc    = 1 + (oor_p - 1) * (1 + S) + oor_j;
          exp_done   = oor_cyc + 1;
          nxt_cur    = exp_dir ? m_cur + (oor_p - 1) : m_cur - (oor_p - 1);
          nxt_err    = 1'b1;
        end else begin
          exp_pulses = n;
          exp_done   = 1 + n * (1 + S);
          nxt_cur    = tgt;
        end
      end
    end

    @(negedge fab_clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready got=%b want=1", nm, req_ready);
    end
    checks++;
    if (cur_tap !== 8'(m_cur)) begin
      errors++; $display("FAIL %s idle_cur_tap got=%0d want=%0d", nm, cur_tap, m_cur);
    end
    checks++;
    if (err_oor !== m_err) begin
      errors++; $display("FAIL %s idle_err_oor got=%b want=%b", nm, err_oor, m_err);
    end
    checks++;
    if (step_cnt !== exp_steps()) begin
      errors++; $display("FAIL %s idle_step_cnt got=%0d want=%0d", nm, step_cnt, exp_steps());
    end

    req_valid = 1'b1;
    req_load  = ld;
    req_tap   = 8'(tap);
    @(posedge fab_clk);
    pulses    = 0;
    done_seen = 1'b0;
    for (int c = 1; c <= BUDGET && !done_seen; c++) begin
      @(negedge fab_clk);
      req_valid = 1'b0;
      if (mv === 1'b1) begin
        checks++;
        if (pulses >= exp_pulses || c != 1 + pulses * (1 + S)) begin
          errors++; $display("FAIL %s move_timing cycle=%0d pulse=%0d want_pulses=%0d", nm, c, pulses, exp_pulses);
        end
        checks++;
        if (dir !== exp_dir) begin
          errors++; $display("FAIL %s direction got=%b want=%b", nm, dir, exp_dir);
        end
        pulses++;
      end
      if (ld_o === 1'b1) begin
        checks++;
        if (!ld || c != 1) begin
          errors++; $display("FAIL %s load_pulse cycle=%0d got=1 want_cycle=%0d", nm, c, ld ? 1 : -1);
        end
      end
      if (ld && c == 1) begin
        checks++;
        if (ld_o !== 1'b1) begin
          errors++; $display("FAIL %s load_missing got=%b want=1", nm, ld_o);
        end
      end
      checks++;
      if (mv === 1'b1 && ld_o === 1'b1) begin
        errors++; $display("FAIL %s move_load_overlap got=11 want=not both", nm);
      end
      if (done === 1'b1) begin
        done_seen = 1'b1;
        checks++;
        if (c != exp_done) begin
          errors++; $display("FAIL %s done_cycle got=%0d want=%0d", nm, c, exp_done);
        end
      end else begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++; $display("FAIL %s busy_ready cycle=%0d got=%b want=0", nm, c, req_ready);
        end
      end
      oor = (c == oor_cyc) || (ld && oor_on_load && c >= 2 && c <= 1 + S);
    end
    oor = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++; $display("FAIL %s done_timeout got=none want=cycle %0d", nm, exp_done);
    end
    checks++;
    if (pulses != exp_pulses) begin
      errors++; $display("FAIL %s pulse_count got=%0d want=%0d", nm, pulses, exp_pulses);
    end
    m_cur    = nxt_cur;
    m_err    = nxt_err;
    m_dir    = exp_dir;
    m_steps += exp_pulses;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_tap = '0; oor = 1'b0;
    repeat (3) @(negedge fab_clk);
    checks++;
    if ({req_ready, mv, ld_o, done, dir, err_oor} !== 6'b100000) begin
      errors++; $display("FAIL reset_flags got=%b want=100000", {req_ready, mv, ld_o, done, dir, err_oor});
    end
    checks++;
    if (cur_tap !== 8'(INIT_TAP)) begin
      errors++; $display("FAIL reset_cur_tap got=%0d want=%0d", cur_tap, INIT_TAP);
    end
    checks++;
    if (step_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_step_cnt got=%0d want=0", step_cnt);
    end
    arst_n = 1'b1;
  endtask

  task automatic test_move_up();   run_req(1'b0, 4, 0, 0, 1'b0, "move_up");     endtask
  task automatic test_move_down(); run_req(1'b0, 2, 0, 0, 1'b0, "move_down");   endtask
  task automatic test_zero();      run_req(1'b0, 2, 0, 0, 1'b0, "zero_dist");   endtask
  task automatic test_load();      run_req(1'b1, 0, 0, 0, 1'b1, "load_oor_ign"); endtask

  task automatic test_oor();
    run_req(1'b0, 10, 3, 2, 1'b0, "oor_stop");
    run_req(1'b1, 0, 0, 0, 1'b0, "load_clear");
  endtask

  task automatic test_clamp();     run_req(1'b0, 200, 0, 0, 1'b0, "clamp");     endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      bit ld;
      int p, j;
      ld = ($urandom_range(0, 4) == 0);
      p  = 0;
      j  = 0;
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(1, 4);
        j = $urandom_range(1, S);
      end
      run_req(ld, $urandom_range(0, 255), p, j, ld, "random");
    end
  endtask

  task automatic test_mid_reset();
    run_req(1'b1, 0, 0, 0, 1'b0, "pre_reset_load");
    @(negedge fab_clk);
    req_valid = 1'b1; req_load = 1'b0; req_tap = 8'd200;
    @(posedge fab_clk);
    @(negedge fab_clk);
    req_valid = 1'b0;
    repeat (13) @(negedge fab_clk);
    arst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, mv, ld_o, done, dir, err_oor} !== 6'b100000) begin
      errors++; $display("FAIL mid_reset_flags got=%b want=100000", {req_ready, mv, ld_o, done, dir, err_oor});
    end
    checks++;
    if (cur_tap !== 8'(INIT_TAP)) begin
      errors++; $display("FAIL mid_reset_cur_tap got=%0d want=%0d", cur_tap, INIT_TAP);
    end
    checks++;
    if (step_cnt !== 16'h0) begin
      errors++; $display("FAIL mid_reset_step_cnt got=%0d want=0", step_cnt);
    end
    @(negedge fab_clk);
    arst_n  = 1'b1;
    m_cur   = INIT_TAP;
    m_err   = 1'b0;
    m_dir   = 1'b0;
    m_steps = 0;
    run_req(1'b1, 0, 0, 0, 1'b0, "post_reset_load");
    run_req(1'b0, 7, 0, 0, 1'b0, "post_reset_move");
  endtask

  task automatic test_final_state();
    @(negedge fab_clk);
    checks++;
    if (cur_tap !== 8'(m_cur) || err_oor !== m_err || req_ready !== 1'b1) begin
      errors++; $display("FAIL final_state got cur=%0d err=%b rdy=%b want cur=%0d err=%b rdy=1",
                         cur_tap, err_oor, req_ready, m_cur, m_err);
    end
    checks++;
    if (step_cnt !== exp_steps()) begin
      errors++; $display("FAIL final_step_cnt got=%0d want=%0d", step_cnt, exp_steps());
    end
  endtask

  initial begin
    test_reset();
    test_move_up();
    test_move_down();
    test_zero();
    test_load();
    test_oor();
    test_clamp();
    test_random();
    test_mid_reset();
    test_final_state();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
